// File: rtl/sha_nonce_dispatcher.sv
// sha_nonce_dispatcher
// Feeds the SHA hashing pipeline: accepts one work unit (midstate, header tail,
// inclusive nonce range), emits one beat per clock across the range, then waits
// PIPE_DEPTH cycles for the last beat to leave the pipeline and pulses done.
//
// Optional feature macro: SHA_DISPATCH_ABORT_EN
//   Adds the abort input and the done_aborted output. When abort is sampled high
//   in RUN, beats stop, the range is dropped and the drain still runs.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | work_ready high, waiting for a work unit
// RUN    | one beat on the outputs every cycle, nonce counting toward end
// DRAIN  | no beats; counting down until the last beat has left the pipe
module sha_nonce_dispatcher #(
    parameter int MIDSTATE_WIDTH = 256,
    parameter int TAIL_WIDTH     = 96,
    parameter int NONCE_WIDTH    = 32,
    parameter int PIPE_DEPTH     = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [MIDSTATE_WIDTH-1:0] work_midstate,
    input  logic [TAIL_WIDTH-1:0]     work_tail,
    input  logic [NONCE_WIDTH-1:0]    work_nonce_start,
    input  logic [NONCE_WIDTH-1:0]    work_nonce_end,
`ifdef SHA_DISPATCH_ABORT_EN
    input  logic                      abort,
    output logic                      done_aborted,
`endif
    output logic                      out_valid,
    output logic [MIDSTATE_WIDTH-1:0] out_midstate,
    output logic [TAIL_WIDTH-1:0]     out_tail,
    output logic [NONCE_WIDTH-1:0]    out_nonce,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    // Wide enough to hold PIPE_DEPTH-1 and never zero bits, even for PIPE_DEPTH=1.
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NONCE_WIDTH-1:0] r_nonce_end;
    logic [CNT_W-1:0]       r_drain_cnt;

    logic [NONCE_WIDTH-1:0] w_next_nonce;
    logic                   w_is_last;
    logic                   w_abort;

    // The beat on the outputs is the counter itself, so "last" compares the
    // presented nonce; modulo arithmetic makes wrap-around ranges free.
    assign w_next_nonce = out_nonce + NONCE_WIDTH'(1);
    assign w_is_last    = (out_nonce == r_nonce_end);

`ifdef SHA_DISPATCH_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Main dispatcher FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_nonce_end  <= '0;
            r_drain_cnt  <= '0;
            work_ready   <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_nonce    <= '0;
            out_midstate <= '0;
            out_tail     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (work_valid) begin
                        r_state      <= ST_RUN;
                        r_nonce_end  <= work_nonce_end;
                        out_midstate <= work_midstate;
                        out_tail     <= work_tail;
                        out_nonce    <= work_nonce_start;
                        out_last     <= (work_nonce_start == work_nonce_end);
                        out_valid    <= 1'b1;
                        work_ready   <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The final beat wins over a simultaneous abort.
                    if (w_is_last || w_abort) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= CNT_W'(PIPE_DEPTH - 1);
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        done        <= (PIPE_DEPTH == 1);
                    end else begin
                        out_nonce <= w_next_nonce;
                        out_last  <= (w_next_nonce == r_nonce_end);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state    <= ST_IDLE;
                        work_ready <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                        done        <= (r_drain_cnt == CNT_W'(1));
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    work_ready <= 1'b1;
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA_DISPATCH_ABORT_EN
    logic r_aborted;

    // Remember whether the range was cut short and qualify the done pulse with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_aborted    <= 1'b0;
            done_aborted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_is_last && abort) begin
                        r_aborted    <= 1'b1;
                        done_aborted <= (PIPE_DEPTH == 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_aborted    <= 1'b0;
                        done_aborted <= 1'b0;
                    end else begin
                        done_aborted <= (r_drain_cnt == CNT_W'(1)) && r_aborted;
                    end
                end
                default: begin
                    r_aborted    <= 1'b0;
                    done_aborted <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sha_nonce_dispatcher.sv
// Directed bench for sha_nonce_dispatcher with PIPE_DEPTH=4.
// Define SHA_DISPATCH_ABORT_EN for both files to exercise the abort scenarios.
module tb_sha_nonce_dispatcher;

    localparam int PD = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_tail;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic         out_valid;
    logic [255:0] out_midstate;
    logic [95:0]  out_tail;
    logic [31:0]  out_nonce;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef SHA_DISPATCH_ABORT_EN
    logic         abort;
    logic         done_aborted;
    int           g_abort_at;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] q_nonce[$];
    int          q_cyc[$];
    int          last_cyc, last_cnt, done_cyc, done_cnt, done_ab_cnt, fld_bad;
    logic        post_ready, post_done;
    bit          timeout;

    always #5 clk = ~clk;

    sha_nonce_dispatcher #(
        .MIDSTATE_WIDTH (256),
        .TAIL_WIDTH     (96),
        .NONCE_WIDTH    (32),
        .PIPE_DEPTH     (PD)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .work_valid       (work_valid),
        .work_ready       (work_ready),
        .work_midstate    (work_midstate),
        .work_tail        (work_tail),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
`ifdef SHA_DISPATCH_ABORT_EN
        .abort            (abort),
        .done_aborted     (done_aborted),
`endif
        .out_valid        (out_valid),
        .out_midstate     (out_midstate),
        .out_tail         (out_tail),
        .out_nonce        (out_nonce),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one unit for a single edge, then scramble the offered fields.
    task automatic send_work(input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] m, input logic [95:0] t);
        work_valid       = 1'b1;
        work_nonce_start = s;
        work_nonce_end   = e;
        work_midstate    = m;
        work_tail        = t;
        tick();
        work_valid       = 1'b0;
        work_nonce_start = $urandom;
        work_nonce_end   = $urandom;
        work_midstate    = {8{$urandom}};
        work_tail        = {$urandom, $urandom, $urandom};
    endtask

    // Record beats from cycle 0 (first cycle after accept) until one cycle past done.
    task automatic collect(input logic [255:0] m, input logic [95:0] t, input int budget);
        q_nonce.delete();
        q_cyc.delete();
        last_cyc = -1; last_cnt = 0; done_cyc = -1; done_cnt = 0; done_ab_cnt = 0;
        fld_bad = 0; post_ready = 1'b0; post_done = 1'b1; timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (out_valid) begin
                q_nonce.push_back(out_nonce);
                q_cyc.push_back(c);
                if (out_midstate !== m || out_tail !== t) fld_bad++;
                if (out_last) begin
                    last_cyc = c;
                    last_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
`ifdef SHA_DISPATCH_ABORT_EN
                if (done_aborted) done_ab_cnt++;
`endif
            end
`ifdef SHA_DISPATCH_ABORT_EN
            abort = (c == g_abort_at);
`endif
            tick();
`ifdef SHA_DISPATCH_ABORT_EN
            abort = 1'b0;
`endif
            if (done_cyc == c) begin
                post_ready = work_ready;
                post_done  = done;
                timeout    = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (work_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || out_nonce !== 32'h0 || out_midstate !== 256'h0 || out_tail !== 96'h0) begin
            errors++;
            $display("FAIL reset_values got ready=%b valid=%b last=%b busy=%b done=%b nonce=%h want 1 0 0 0 0 0",
                     work_ready, out_valid, out_last, busy, done, out_nonce);
        end
`ifdef SHA_DISPATCH_ABORT_EN
        checks++;
        if (done_aborted !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_aborted got %b want 0", done_aborted);
        end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    // Shared expectations for a simple range: beats on cycles 0..n-1, last on n-1, done on n-1+PD.
    task automatic check_range(input string name, input logic [31:0] s, input int n);
        logic [31:0] exp_n;
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL %s_timeout got no done want done", name);
        end
        checks++;
        if (q_nonce.size() != n) begin
            errors++;
            $display("FAIL %s_beat_count got %0d want %0d", name, q_nonce.size(), n);
        end
        exp_n = s;
        for (int i = 0; i < n && i < q_nonce.size(); i++) begin
            checks++;
            if (q_nonce[i] !== exp_n || q_cyc[i] != i) begin
                errors++;
                $display("FAIL %s_beat[%0d] got %h@%0d want %h@%0d", name, i, q_nonce[i], q_cyc[i], exp_n, i);
            end
            exp_n = exp_n + 32'd1;
        end
        checks++;
        if (last_cyc != n - 1 || last_cnt != 1) begin
            errors++;
            $display("FAIL %s_last got cyc=%0d cnt=%0d want cyc=%0d cnt=1", name, last_cyc, last_cnt, n - 1);
        end
        checks++;
        if (done_cyc != n - 1 + PD || done_cnt != 1 || done_ab_cnt != 0) begin
            errors++;
            $display("FAIL %s_done got cyc=%0d cnt=%0d ab=%0d want cyc=%0d cnt=1 ab=0",
                     name, done_cyc, done_cnt, done_ab_cnt, n - 1 + PD);
        end
        checks++;
        if (post_ready !== 1'b1 || post_done !== 1'b0 || fld_bad != 0) begin
            errors++;
            $display("FAIL %s_after_done got ready=%b done=%b fld_bad=%0d want 1 0 0",
                     name, post_ready, post_done, fld_bad);
        end
    endtask

    task automatic test_basic_range;
        send_work(32'h10, 32'h13, {8{32'hA5A5_0001}}, {3{32'h1234_5678}});
        checks++;
        if (busy !== 1'b1 || work_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%b ready=%b want 1 0", busy, work_ready);
        end
        collect({8{32'hA5A5_0001}}, {3{32'h1234_5678}}, 40);
        check_range("basic", 32'h10, 4);
    endtask

    task automatic test_single_beat;
        send_work(32'hFFFF_FFFF, 32'hFFFF_FFFF, {8{32'h0BAD_F00D}}, {3{32'hCAFE_0002}});
        collect({8{32'h0BAD_F00D}}, {3{32'hCAFE_0002}}, 40);
        check_range("single", 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_wrap;
        send_work(32'hFFFF_FFFE, 32'h0000_0001, {8{32'h5555_0003}}, {3{32'h7777_0003}});
        collect({8{32'h5555_0003}}, {3{32'h7777_0003}}, 40);
        check_range("wrap", 32'hFFFF_FFFE, 4);
    endtask

    task automatic test_back_to_back;
        logic [31:0]  exp_n[5];
        int           exp_c[5];
        logic [255:0] cur_m;
        int           d_cyc[$];
        int           acc_cyc;
        int           accepted;
        bit           finished;
        exp_n = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h201};
        exp_c = '{0, 1, 2, 8, 9};
        q_nonce.delete();
        q_cyc.delete();
        fld_bad = 0; acc_cyc = -1; accepted = 0; finished = 1'b0;
        work_valid = 1'b1;
        work_nonce_start = 32'h100; work_nonce_end = 32'h102;
        work_midstate = {8{32'h1111_1111}}; work_tail = {3{32'h1}};
        tick();
        cur_m = {8{32'h1111_1111}};
        work_nonce_start = 32'h200; work_nonce_end = 32'h201;
        work_midstate = {8{32'h2222_2222}}; work_tail = {3{32'h2}};
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                q_nonce.push_back(out_nonce);
                q_cyc.push_back(c);
                if (out_midstate !== cur_m) fld_bad++;
            end
            if (done) d_cyc.push_back(c);
            if (work_valid && work_ready) begin
                acc_cyc  = c;
                accepted = 1;
            end
            tick();
            if (accepted == 1) begin
                work_valid = 1'b0;
                cur_m      = {8{32'h2222_2222}};
                accepted   = 2;
            end
            if (d_cyc.size() == 2) begin
                finished = 1'b1;
                break;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL b2b_timeout got %0d done pulses want 2", d_cyc.size());
        end
        checks++;
        if (acc_cyc != 7) begin
            errors++;
            $display("FAIL b2b_accept_cycle got %0d want 7", acc_cyc);
        end
        checks++;
        if (q_nonce.size() != 5) begin
            errors++;
            $display("FAIL b2b_beat_count got %0d want 5", q_nonce.size());
        end
        for (int i = 0; i < 5 && i < q_nonce.size(); i++) begin
            checks++;
            if (q_nonce[i] !== exp_n[i] || q_cyc[i] != exp_c[i]) begin
                errors++;
                $display("FAIL b2b_beat[%0d] got %h@%0d want %h@%0d", i, q_nonce[i], q_cyc[i], exp_n[i], exp_c[i]);
            end
        end
        checks++;
        if (d_cyc.size() != 2 || d_cyc[0] != 6 || d_cyc[1] != 13) begin
            errors++;
            $display("FAIL b2b_done_cycles got n=%0d want 6,13", d_cyc.size());
        end
        checks++;
        if (fld_bad != 0) begin
            errors++;
            $display("FAIL b2b_midstate got %0d bad beats want 0", fld_bad);
        end
        tick();
    endtask

    task automatic test_reset_mid_run;
        int dones;
        int beats;
        send_work(32'h0, 32'h9, {8{32'h3333_3333}}, {3{32'h3}});
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_nonce !== 32'h2) begin
            errors++;
            $display("FAIL rst_mid_third_beat got valid=%b nonce=%h want 1 2", out_valid, out_nonce);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || work_ready !== 1'b1 || busy !== 1'b0 || out_nonce !== 32'h0 ||
            out_midstate !== 256'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after got valid=%b ready=%b busy=%b nonce=%h done=%b want 0 1 0 0 0",
                     out_valid, work_ready, busy, out_nonce, done);
        end
        reset_n = 1'b1;
        dones = 0;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dones++;
            if (out_valid) beats++;
        end
        checks++;
        if (dones != 0 || beats != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got done=%0d beats=%0d want 0 0", dones, beats);
        end
    endtask

`ifdef SHA_DISPATCH_ABORT_EN
    task automatic test_abort;
        g_abort_at = 1;
        send_work(32'h0, 32'd99, {8{32'h4444_4444}}, {3{32'h4}});
        collect({8{32'h4444_4444}}, {3{32'h4}}, 40);
        g_abort_at = -1;
        checks++;
        if (timeout || q_nonce.size() != 2 || q_nonce[0] !== 32'h0 || q_nonce[1] !== 32'h1) begin
            errors++;
            $display("FAIL abort_beats got n=%0d timeout=%0d want 2 beats 0,1", q_nonce.size(), timeout);
        end
        checks++;
        if (last_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_last got %0d want 0", last_cnt);
        end
        checks++;
        if (done_cyc != 1 + PD || done_cnt != 1 || done_ab_cnt != 1 || post_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_done got cyc=%0d cnt=%0d ab=%0d ready=%b want %0d 1 1 1",
                     done_cyc, done_cnt, done_ab_cnt, post_ready, 1 + PD);
        end
        checks++;
        if (done_aborted !== 1'b0) begin
            errors++;
            $display("FAIL abort_flag_clears got %b want 0", done_aborted);
        end
    endtask

    task automatic test_abort_on_last;
        g_abort_at = 1;
        send_work(32'h20, 32'h21, {8{32'h6666_6666}}, {3{32'h6}});
        collect({8{32'h6666_6666}}, {3{32'h6}}, 40);
        g_abort_at = -1;
        check_range("abort_last", 32'h20, 2);
    endtask
`endif

    initial begin
        reset_n          = 1'b0;
        work_valid       = 1'b0;
        work_midstate    = '0;
        work_tail        = '0;
        work_nonce_start = '0;
        work_nonce_end   = '0;
`ifdef SHA_DISPATCH_ABORT_EN
        abort            = 1'b0;
        g_abort_at       = -1;
`endif
        test_reset();
        test_basic_range();
        test_single_beat();
        test_wrap();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SHA_DISPATCH_ABORT_EN
        test_abort();
        test_abort_on_last();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
